// File: rtl/grid_stream_if.sv
// Handshake bundle between the frame source/Arduino side and grid_frame_streamer.
// The streamer connects through the slave modport; the environment uses master.
interface grid_stream_if #(
  parameter int FRAME_BITS = 256
);
  logic                  start;
  logic [FRAME_BITS-1:0] frame;
  logic                  ack_a;
  logic                  ack_b;
  logic [7:0]            data_a;
  logic [7:0]            data_b;
  logic                  req_a;
  logic                  req_b;
  logic                  busy;
  logic                  done;

  modport master (
    output start, frame, ack_a, ack_b,
    input  data_a, data_b, req_a, req_b, busy, done
  );

  modport slave (
    input  start, frame, ack_a, ack_b,
    output data_a, data_b, req_a, req_b, busy, done
  );
endinterface

// File: rtl/grid_frame_streamer.sv
// Captures one grid frame on start and streams it as bytes on two independent
// req/ack channels, each paced by an unsynchronised ack clock from an Arduino.
module grid_frame_streamer #(
  parameter int FRAME_BITS  = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clock,
  input  logic         reset,
  grid_stream_if.slave bus
);
  localparam int N    = FRAME_BITS / 16;
  localparam int IW   = $clog2(N) + 1;
  localparam int HALF = FRAME_BITS / 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state;
  logic [FRAME_BITS-1:0]  shadow;
  logic [IW-1:0]          idx_a;
  logic [IW-1:0]          idx_b;
  logic                   req_a;
  logic                   req_b;
  logic                   busy;
  logic                   done;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   hist_a;
  logic                   hist_b;
  logic                   edge_a;
  logic                   edge_b;
  logic [IW-2:0]          sel_a;
  logic [IW-2:0]          sel_b;

  // Ack synchronisers run in every state so edge history stays coherent.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= 1'b0;
      hist_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.ack_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.ack_b};
      hist_a <= sync_a[SYNC_STAGES-1];
      hist_b <= sync_b[SYNC_STAGES-1];
    end
  end

  assign edge_a = sync_a[SYNC_STAGES-1] & ~hist_a;
  assign edge_b = sync_b[SYNC_STAGES-1] & ~hist_b;

  // NOTE: the shadow frame is a plain register bank, so it is reset along with
  // the control state; a mid-frame reset must leave no stale bytes behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      shadow <= '0;
      idx_a  <= '0;
      idx_b  <= '0;
      req_a  <= 1'b0;
      req_b  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            shadow <= bus.frame;
            idx_a  <= '0;
            idx_b  <= '0;
            req_a  <= 1'b1;
            req_b  <= 1'b1;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (!req_a && !req_b) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (edge_a && req_a) begin
              idx_a <= idx_a + 1'b1;
              if (idx_a == LAST) req_a <= 1'b0;
            end
            if (edge_b && req_b) begin
              idx_b <= idx_b + 1'b1;
              if (idx_b == LAST) req_b <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Index N only occurs with req low, so the wrapped low bits never reach the bus.
  assign sel_a = idx_a[IW-2:0];
  assign sel_b = idx_b[IW-2:0];

  assign bus.data_a = req_a ? shadow[8*sel_a +: 8]        : 8'h00;
  assign bus.data_b = req_b ? shadow[HALF + 8*sel_b +: 8] : 8'h00;
  assign bus.req_a  = req_a;
  assign bus.req_b  = req_b;
  assign bus.busy   = busy;
  assign bus.done   = done;
endmodule

// File: tb/tb_grid_frame_streamer.sv
// Directed bench for grid_frame_streamer: reset/idle, lockstep and skewed
// channels, start while busy, mid-frame reset and simultaneous last edges.
module tb_grid_frame_streamer;
  localparam int FB = 256;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   done_cnt;

  logic [FB-1:0] f1;
  logic [FB-1:0] f2;

  grid_stream_if #(.FRAME_BITS(FB)) bus ();

  grid_frame_streamer #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b);
    bus.ack_a = a;
    bus.ack_b = b;
    repeat (4) tick();
    bus.ack_a = 1'b0;
    bus.ack_b = 1'b0;
    repeat (4) tick();
  endtask

  function automatic logic [7:0] byte_of(input logic [FB-1:0] f, input int i);
    return f[8*i +: 8];
  endfunction

  function automatic logic [3:0] ctl();
    return {bus.req_a, bus.req_b, bus.busy, bus.done};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    done_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      f1[8*i +: 8] = 8'(i);
      f2[8*i +: 8] = 8'(8'hFF - i);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.frame = f1;
    bus.ack_a = 1'b0;
    bus.ack_b = 1'b0;

    // Reset held: nothing may move.
    repeat (2) tick();
    bus.start = 1'b1;
    pulse(1'b1, 1'b1);
    bus.start = 1'b0;
    check("rst_ctl", 32'(ctl()), 32'h0);
    check("rst_data", {16'h0, bus.data_a, bus.data_b}, 32'h0);

    // Released, acks with no start.
    reset = 1'b1;
    repeat (2) tick();
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    check("idle_ctl", 32'(ctl()), 32'h0);
    check("idle_data", {16'h0, bus.data_a, bus.data_b}, 32'h0);

    // Single frame, lockstep acks.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_ctl", 32'(ctl()), 32'b1110);
    check("start_da", 32'(bus.data_a), 32'h00);
    check("start_db", 32'(bus.data_b), 32'h10);
    for (int i = 0; i < 16; i++) begin
      bus.ack_a = 1'b1;
      bus.ack_b = 1'b1;
      tick();
      tick();
      check("lock_hold_a", 32'(bus.data_a), 32'(i));
      check("lock_hold_b", 32'(bus.data_b), 32'(16 + i));
      tick();
      if (i < 15) begin
        check("lock_step_a", 32'(bus.data_a), 32'(i + 1));
        check("lock_step_b", 32'(bus.data_b), 32'(17 + i));
        tick();
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        repeat (4) tick();
      end else begin
        check("last_ctl", 32'(ctl()), 32'b0010);
        check("last_data", {16'h0, bus.data_a, bus.data_b}, 32'h0);
        tick();
        check("done_ctl", 32'(ctl()), 32'b0011);
        // Start during the DONE cycle is ignored; held one more cycle it is taken.
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        bus.start = 1'b1;
        bus.frame = f2;
        tick();
        check("after_done_ctl", 32'(ctl()), 32'b0000);
        tick();
        bus.start = 1'b0;
        check("restart_ctl", 32'(ctl()), 32'b1110);
        check("restart_da", 32'(bus.data_a), 32'(byte_of(f2, 0)));
        check("restart_db", 32'(bus.data_b), 32'(byte_of(f2, 16)));
        check("lock_done_cnt", 32'(done_cnt), 32'd1);
      end
    end

    // Skewed channels: A finishes first, B long afterwards.
    repeat (4) tick();
    for (int i = 0; i < 16; i++) begin
      pulse(1'b1, 1'b0);
      if (i < 15) check("skew_a", 32'(bus.data_a), 32'(byte_of(f2, i + 1)));
      check("skew_b_hold", 32'(bus.data_b), 32'(byte_of(f2, 16)));
    end
    check("skew_a_end_ctl", 32'(ctl()), 32'b0110);
    check("skew_a_end_da", 32'(bus.data_a), 32'h0);
    repeat (20) pulse(1'b1, 1'b0);
    repeat (40) tick();
    check("gap_ctl", 32'(ctl()), 32'b0110);
    check("gap_data", {16'h0, bus.data_a, bus.data_b}, {24'h0, byte_of(f2, 16)});
    check("gap_done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        bus.start = 1'b1;
        bus.frame = f1;
        tick();
        bus.start = 1'b0;
        check("busy_start_ctl", 32'(ctl()), 32'b0110);
      end
      pulse(1'b0, 1'b1);
      if (i < 15) check("skew_b", 32'(bus.data_b), 32'(byte_of(f2, 17 + i)));
    end
    check("skew_end_ctl", 32'(ctl()), 32'b0000);
    check("skew_done_cnt", 32'(done_cnt), 32'd2);

    // Reset mid-frame.
    bus.start = 1'b1;
    bus.frame = f1;
    tick();
    bus.start = 1'b0;
    repeat (5) pulse(1'b1, 1'b1);
    check("mid_da", 32'(bus.data_a), 32'h05);
    check("mid_db", 32'(bus.data_b), 32'h15);
    bus.ack_a = 1'b1;
    reset = 1'b0;
    #1;
    check("abort_ctl", 32'(ctl()), 32'b0000);
    check("abort_data", {16'h0, bus.data_a, bus.data_b}, 32'h0);
    repeat (3) tick();
    bus.ack_a = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (4) tick();
    check("abort_done_cnt", 32'(done_cnt), 32'd2);
    check("abort_idle_ctl", 32'(ctl()), 32'b0000);
    bus.start = 1'b1;
    bus.frame = f2;
    tick();
    bus.start = 1'b0;
    check("post_rst_da", 32'(bus.data_a), 32'(byte_of(f2, 0)));
    check("post_rst_db", 32'(bus.data_b), 32'(byte_of(f2, 16)));
    pulse(1'b1, 1'b1);
    check("post_rst_da1", 32'(bus.data_a), 32'(byte_of(f2, 1)));
    check("post_rst_db1", 32'(bus.data_b), 32'(byte_of(f2, 17)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/grid_frame_streamer.md
# grid_frame_streamer

Downstream stage between the grid engine's 256-bit `grid_out` snapshot and the two Arduino LED drivers. On a start strobe it captures one frame and streams it as bytes over two independent req/ack channels, one per Arduino. Each channel is paced by an externally generated, unsynchronised acknowledge clock. Channel A carries frame bits 127:0 and channel B carries bits 255:128.

## Interface
- `FRAME_BITS`, default 256: frame width; must be a multiple of 16.
- `SYNC_STAGES`, default 2: synchroniser depth on each ack input; minimum 2.
- `clock`  in  1: single system clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Deassertion is used synchronously.
- `start`  in  1: one-cycle request to capture and send `frame`.
- `frame`  in  FRAME_BITS: grid snapshot; sampled only on an accepted start.
- `ack_a`, `ack_b`  in  1: Arduino pacing clocks, asynchronous to `clock`. Each rising edge consumes one byte.
- `data_a`, `data_b`  out  8: current byte for each channel.
- `req_a`, `req_b`  out  1: channel has a valid byte pending.
- `busy`  out  1: a frame is in flight.
- `done`  out  1: one-cycle pulse when both channels have finished.

## Operation
- Data path:
  - Shadow register `shadow[FRAME_BITS-1:0]`.
  - Per-channel byte index `idx_a` / `idx_b`, each `log2(FRAME_BITS/16)+1` bits wide.
  - `N = FRAME_BITS/16` bytes per channel (16 at the default).
- Byte mapping:
  - `data_a = shadow[8*idx_a +: 8]`.
  - `data_b = shadow[FRAME_BITS/2 + 8*idx_b +: 8]`.
  - No bit reversal.
  - `data_x` is 0 whenever `req_x` is 0.
- Ack path: each ack input passes through `SYNC_STAGES` flops, then a history flop. The edge pulse is `sync & ~hist`. The synchronisers run in every state.
- FSM states: IDLE, SEND, DONE.
  - IDLE, on `start`=1: load shadow, clear both indices, set `req_a`/`req_b`, move to SEND.
  - SEND: an edge on channel x while `req_x`=1 increments `idx_x`. The edge that makes `idx_x` equal N clears `req_x`. Once both reqs are 0, move to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `busy` = 1 in SEND and DONE.
- `start` while `busy` is ignored entirely: shadow, indices and reqs are untouched.
- Ack edges are ignored in IDLE, in DONE, and on a channel whose req is already 0. Indices never exceed N.
- Channels are fully independent. Simultaneous edges on A and B in the same cycle both advance.
- If both channels finish in the same cycle, the block enters DONE once and emits one `done` pulse.
- Reset mid-frame aborts the frame. No `done` pulse is emitted, and everything returns to reset values.

## Timing
- Reset values: `req_a`=`req_b`=0, `data_a`=`data_b`=0, `busy`=0, `done`=0, state IDLE, indices 0, shadow 0, all sync/history flops 0.
- Start latency: `start` sampled high at edge k → at edge k+1 (i.e. after edge k), `busy`, `req_a` and `req_b` are 1, and `data_a`/`data_b` show byte 0.
- Ack latency (with `SYNC_STAGES`=2): the ack pin is stable high before edge k → the index updates at edge k+2. The new `data_x` is visible after edge k+2.
- Ack minimum timing: ack high and low phases must each be at least `SYNC_STAGES`+1 `clock` cycles. Shorter pulses may be lost; they are not required to be counted.
- Done timing: the last required edge is processed at edge m → DONE state after m+1, `done` high for that cycle only, IDLE and `busy`=0 after m+2.
- Back-to-back frames: the earliest accepted next `start` is the cycle `busy` reads 0.

## Test plan
- Reset and idle: hold `reset`=0, toggle `ack_a`/`ack_b` and `start` → all outputs stay 0. Release reset with no `start` and toggle acks → outputs stay 0.
- Single frame with lockstep acks: `frame` = byte i holds value i (0x00..0x1F), start, then 16 ack pulses on both channels at 8-cycle spacing.
  - `data_a` steps 0x00..0x0F and `data_b` steps 0x10..0x1F, each change 3 cycles after the corresponding ack rise.
  - `req_x` drops after the 16th edge, and exactly one `done` pulse follows.
- Skewed channels: finish channel A entirely, then channel B 200 cycles later.
  - `req_a` low with `data_a`=0 while B continues.
  - `done` pulses only after B's 16th edge.
  - Extra `ack_a` edges during that gap change nothing.
- Start while busy: pulse `start` with a different `frame` mid-stream → the remaining bytes still come from the original frame and no restart occurs. A `start` on the cycle after `done` is accepted.
- Reset mid-frame: assert `reset` after byte 5 of channel A → all outputs are 0 immediately, no `done` pulse. The next `start` sends from byte 0.
- Simultaneous last edges: A and B receive their 16th edges on the same `clock` cycle → exactly one `done` pulse, and `busy` falls 2 cycles after that edge is processed.
